// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transfer sequencer and its command FIFO.
package spi_seq_pkg;

    localparam int DEF_BIT_WIDTH      = 16;
    localparam int DEF_DEPTH          = 4;
    localparam int DEF_GAP_CYCLES     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Response word reported when the master never signals done; sliced to BIT_WIDTH.
    localparam logic [63:0] TIMEOUT_RSP = '1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        GAP
    } seq_state_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO (DEPTH x BIT_WIDTH) with occupancy count; head is read straight
// from the array and registered by the consumer at launch.
module spi_cmd_fifo
    import spi_seq_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [BIT_WIDTH-1:0]         i_push_data,
    input  logic                         i_pop,
    output logic [BIT_WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [BIT_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Queues command words and launches one SPI master frame per word, returning the received word.
// Define SPI_SEQ_TIMEOUT_EN to abort a frame whose done never arrives (sticky err_timeout).
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int BIT_WIDTH      = DEF_BIT_WIDTH,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [BIT_WIDTH-1:0] cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BIT_WIDTH-1:0] rsp_data,
    output logic                 spi_start,
    output logic [BIT_WIDTH-1:0] spi_wdata,
    input  logic                 spi_done,
    input  logic [BIT_WIDTH-1:0] spi_rdata,
    output logic                 busy,
    output logic                 err_timeout
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [BIT_WIDTH-1:0] RSP_ON_TIMEOUT = TIMEOUT_RSP[BIT_WIDTH-1:0];

    seq_state_t           r_state;
    logic [GW-1:0]        r_gap_cnt;
    logic                 r_spi_start;
    logic [BIT_WIDTH-1:0] r_spi_wdata;
    logic                 r_rsp_valid;
    logic [BIT_WIDTH-1:0] r_rsp_data;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;
    logic [BIT_WIDTH-1:0] w_head;
    logic                 w_timeout;

    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == LAUNCH);
    assign cmd_ready = !w_full;
    assign spi_start = r_spi_start;
    assign spi_wdata = r_spi_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != IDLE) || (w_count != '0);

    spi_cmd_fifo #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (cmd_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // A held response blocks launch, so the response register is always free when done arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gap_cnt   <= '0;
            r_spi_start <= 1'b0;
            r_spi_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_spi_start <= 1'b0;
            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (!w_empty && !r_rsp_valid) begin
                        r_state     <= LAUNCH;
                        r_spi_start <= 1'b1;
                        r_spi_wdata <= w_head;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (spi_done || w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= spi_done ? spi_rdata : RSP_ON_TIMEOUT;
                        r_gap_cnt   <= '0;
                        r_state     <= GAP;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_err_timeout;

    assign w_timeout   = (r_state == WAIT_DONE) && !spi_done && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = r_err_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state == WAIT_DONE) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout_cycles;

    assign w_unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign w_timeout               = 1'b0;
    assign err_timeout             = 1'b0;
`endif

endmodule

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

Command/response sequencer placed directly upstream of the SPI master. It buffers outgoing words from a valid/ready command stream and launches one SPI frame per word by pulsing the master's `start` with `wdata` held stable. It captures the master's `rdata` on `done` into a valid/ready response stream and enforces an inter-frame gap so that the master has returned to idle before the next launch.

## Interface
- `BIT_WIDTH`, default 16: SPI frame width. Must match the master.
- `DEPTH`, default 4: command FIFO depth. Power of two, at least 2.
- `GAP_CYCLES`, default 16: idle clk cycles after `done` before the next launch. Must be at least the master's `CLK_DIV`.
- `TIMEOUT_CYCLES`, default 4096: maximum clk cycles to wait for `done`. Used only with the timeout feature.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; asynchronous, active-low; clock clk.
- `cmd_valid`, in, 1: command word offered.
- `cmd_ready`, out, 1: FIFO can accept; equals `!full`.
- `cmd_data`, in, BIT_WIDTH: word to transmit.
- `rsp_valid`, out, 1: response word available.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_data`, out, BIT_WIDTH: received word.
- `spi_start`, out, 1: one-cycle launch pulse to the master. The master acts on the rising edge.
- `spi_wdata`, out, BIT_WIDTH: frame data to the master.
- `spi_done`, in, 1: one-cycle pulse from the master. `spi_rdata` is valid in the same cycle.
- `spi_rdata`, in, BIT_WIDTH: frame data from the master.
- `busy`, out, 1: high when the state is not IDLE or the FIFO is non-empty.
- `err_timeout`, out, 1: sticky timeout flag.

## Operation
- A command is pushed when `cmd_valid && cmd_ready`. The FIFO pops only in LAUNCH. A push into a full FIFO is impossible because `cmd_ready` is low.
- The state machine has four states:
  - IDLE → LAUNCH when the FIFO is non-empty and `rsp_valid` is low. A pending response blocks the launch; this is the backpressure mechanism.
  - LAUNCH lasts exactly 1 cycle and → WAIT_DONE. During LAUNCH: `spi_start` = 1, `spi_wdata` = FIFO head, and the head is popped.
  - WAIT_DONE → GAP on `spi_done`. On that edge `rsp_data` ← `spi_rdata` and `rsp_valid` ← 1.
  - GAP counts `GAP_CYCLES` cycles, then → IDLE.
- `spi_wdata` holds its value from LAUNCH until the next LAUNCH.
- `rsp_valid` clears on `rsp_valid && rsp_ready`. `rsp_data` is stable while `rsp_valid` is high.
- Because of the launch rule, a response slot is always free when `spi_done` arrives, so no response is ever dropped.
- `spi_done` outside WAIT_DONE is ignored: no state change and no response.
- A push and a pop in the same cycle are both performed, and the FIFO count is unchanged.
- FIFO pointers wrap modulo `DEPTH`. full = count == `DEPTH`; empty = count == 0.
- Reset, including mid-frame, empties the FIFO and returns the state to IDLE. Any in-flight frame's `spi_done` arriving afterwards is ignored.

## Timing
- Reset values: `cmd_ready` 1, `rsp_valid` 0, `rsp_data` 0, `spi_start` 0, `spi_wdata` 0, `busy` 0, `err_timeout` 0.
- Command to launch: a command accepted at edge N into an empty FIFO with the block idle gives LAUNCH (`spi_start` = 1) in cycle N+2.
- Done to response: `spi_done` in cycle M gives `rsp_valid` = 1 from cycle M+1.
- Back-to-back frames: the next `spi_start` occurs no earlier than cycle M+1+`GAP_CYCLES`+1.
- All outputs are registered. There is no combinational path from inputs to outputs except `cmd_ready` from the registered FIFO count.

## Configuration
- `SPI_SEQ_TIMEOUT_EN` defined:
  - WAIT_DONE runs a counter. After `TIMEOUT_CYCLES` cycles without `spi_done`, the block sets `err_timeout` (sticky until reset).
  - It then delivers a response with `rsp_data` = all ones and → GAP.
- `SPI_SEQ_TIMEOUT_EN` undefined:
  - WAIT_DONE waits indefinitely.
  - `err_timeout` is tied to 0 and no counter is synthesised.

## Structure
- Package `spi_seq_pkg` holds:
  - the state enum `seq_state_t` (IDLE, LAUNCH, WAIT_DONE, GAP);
  - the default-parameter constants;
  - the all-ones timeout response constant.
- Sub-module `spi_cmd_fifo` is a synchronous FIFO of `DEPTH` x `BIT_WIDTH` with a count output. The sequencer FSM, gap counter and timeout counter live in the top module.

## Test plan
- Single word: push 0xA5C3; slave model returns 0x1234 → `spi_start` pulses once with `spi_wdata` = 0xA5C3 in cycle N+2, and `rsp_data` = 0x1234 one cycle after `spi_done`.
- Burst of 4 with `rsp_ready` = 1: push 0x0001..0x0004 back-to-back → `cmd_ready` stays high; 4 launches in order, each separated by at least `GAP_CYCLES`+2 cycles; responses arrive in order.
- Backpressure: hold `rsp_ready` = 0 with 5 commands offered → 1 frame completes, no second launch, `cmd_ready` = 0 after the FIFO fills. Releasing `rsp_ready` resumes launches.
- Spurious done: pulse `spi_done` while IDLE and during GAP → no `rsp_valid` and no state change.
- Reset mid-frame: assert `rst_n` = 0 during WAIT_DONE with 2 words queued → all outputs return to reset values, the FIFO is empty, and no launch occurs after release.
- Timeout (`SPI_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 64): launch and never return `spi_done` → `err_timeout` = 1 after 64 cycles, `rsp_data` = 0xFFFF, and the next queued word launches after the gap.
